sweep_counter: RTL
==================

Name: sweep_counter

Overview:
Parametrised successor to the free-running BRAM test counter. Generates address/data sweeps for the dual-port block RAM test harness and the particle-filter index walkers.
- Programmable modulo limit, step and direction.
- Single-shot or continuous modes.
- Start/pause/resume/abort control FSM, with wrap and done event pulses.
- Advances only on clk_en, so it can be paced by a slower strobe.

Parameters:
WIDTH, 10, count/limit width in bits (1..32)
STEP_W, 4, step input width in bits (1..WIDTH)

Ports:
clk  in  1  system clock; sole clock domain
rst  in  1  synchronous reset, active-high; overrides clk_en
clk_en  in  1  advance enable; all FSM/count updates occur only on clk edges with clk_en=1
start  in  1  level; IDLE->RUN (load) or PAUSE->RUN (resume)
stop  in  1  level; RUN->PAUSE, PAUSE->IDLE (abort)
dir  in  1  0=count up, 1=count down; sampled at load only
continuous  in  1  1=wrap forever, 0=single sweep; sampled at load only
limit  in  WIDTH  inclusive terminal value; sampled at load only
step  in  STEP_W  increment magnitude; sampled at load only; 0 treated as 1
count  out  WIDTH  current value
busy  out  1  high in RUN or PAUSE
wrap  out  1  one-clk pulse on a terminal crossing in continuous mode
done  out  1  one-clk pulse at single-sweep completion or abort

Behaviour:
- Reset (synchronous, active-high, independent of clk_en): state=IDLE, count=0, busy=0, wrap=0, done=0, all latched config registers=0.
- States: IDLE, RUN, PAUSE. Every transition requires clk_en=1.
- IDLE:
  - start=1 and stop=0 -> RUN.
  - Latch dir, continuous, limit and step (step_eff = step, or 1 if step==0).
  - count <= 0 if up; count <= limit if down. The first advance occurs on the next enabled edge, so latency is 1 enabled cycle from start to first value.
- RUN:
  - stop=1 -> PAUSE; count holds.
  - Otherwise advance once per enabled edge.
  - Up: sum = count + step_eff, computed in WIDTH+1 bits. If sum > limit, that is a terminal event; else count <= sum.
  - Down: if count < step_eff, that is a terminal event; else count <= count - step_eff.
  - Terminal event, continuous=1: count <= 0 (up) or limit (down); wrap=1 for that cycle; stay in RUN.
  - Terminal event, continuous=0: count holds its last in-range value; done=1; -> IDLE.
- PAUSE:
  - stop=1 -> IDLE; count <= 0; done=1 (abort).
  - Else start=1 -> RUN with no reload; the latched config is kept.
  - Else hold.
- start and stop both high in the same enabled cycle: stop wins.
- wrap and done are registered. They are high for exactly one clk cycle, then cleared on the following clk edge even if clk_en=0.
- limit=0: the count stays at 0. Every advance is a terminal event: continuous mode gives wrap on every enabled cycle; single-shot gives done on the first advance.
- limit, dir, step and continuous changes during RUN or PAUSE have no effect until the next load.
- busy = (state != IDLE), registered alongside the state.
- No overflow of WIDTH bits is possible: every stored value is at most limit.

Optional Feature:
Macro SWEEP_PINGPONG_EN.
- Defined: adds input pingpong (1 bit), latched at load. With pingpong=1 and continuous=1, a terminal event reverses the internal direction instead of resetting:
  - Up terminal -> count <= limit, direction becomes down.
  - Down terminal -> count <= 0, direction becomes up.
  - wrap pulses at each reversal.
  - With pingpong=0, behaviour is identical to the base block.
- Not defined: the port is absent and no direction-reversal logic is synthesised.

Test Plan:
- WIDTH=10, limit=5, step=1, up, continuous=1, clk_en=1, pulse start -> count 0,1,2,3,4,5,0,1...; wrap high only in the cycle count returns to 0; busy=1 throughout.
- limit=10, step=3, down, continuous=0 -> count 10,7,4,1, then held at 1; done pulses once; busy falls in the same cycle; state IDLE.
- clk_en high every 3rd cycle, limit=3, up, single-shot -> count changes only on enabled edges; done is exactly 1 clk wide.
- Run to count=4 (limit=9); stop for 2 enabled cycles -> PAUSE then IDLE, count=0, done=1. Repeat, but assert start instead of the second stop -> resumes at 5.
- start=stop=1 in IDLE -> stays IDLE. In RUN -> PAUSE. rst asserted mid-RUN with clk_en=0 -> next clk gives count=0, busy=0, IDLE.
- Feature on: limit=3, step=1, pingpong=1, continuous=1 -> 0,1,2,3,3,2,1,0,0,1...; wrap pulses at each reversal. step=0 with limit=2 behaves as step=1.

Source files
------------

// File: rtl/sweep_counter.sv
// Programmable up/down modulo sweep counter with start/pause/abort control.
// Optional SWEEP_PINGPONG_EN adds a pingpong input that reverses direction at terminals.
module sweep_counter #(
   parameter int WIDTH  = 10,
   parameter int STEP_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   input  logic              start,
   input  logic              stop,
   input  logic              dir,
   input  logic              continuous,
`ifdef SWEEP_PINGPONG_EN
   input  logic              pingpong,
`endif
   input  logic [WIDTH-1:0]  limit,
   input  logic [STEP_W-1:0] step,
   output logic [WIDTH-1:0]  count,
   output logic              busy,
   output logic              wrap,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t           state;
   logic             cfg_dir;
   logic             cfg_cont;
   logic [WIDTH-1:0] cfg_limit;
   logic [WIDTH-1:0] cfg_step;
`ifdef SWEEP_PINGPONG_EN
   logic             cfg_pp;
`endif

   logic [WIDTH-1:0] step_eff;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] wrap_val;
   logic             term;

   assign step_eff = (step == '0) ? WIDTH'(1) : WIDTH'(step);

   // Sum is one bit wider so count+step can never alias below limit.
   always_comb begin
      sum      = {1'b0, count} + {1'b0, cfg_step};
      term     = 1'b0;
      nxt      = count;
      wrap_val = cfg_dir ? cfg_limit : '0;
      if (cfg_dir) begin
         term = (count < cfg_step);
         nxt  = count - cfg_step;
      end else begin
         term = (sum > {1'b0, cfg_limit});
         nxt  = sum[WIDTH-1:0];
      end
`ifdef SWEEP_PINGPONG_EN
      if (cfg_pp)
         wrap_val = cfg_dir ? '0 : cfg_limit;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         busy      <= 1'b0;
         wrap      <= 1'b0;
         done      <= 1'b0;
         cfg_dir   <= 1'b0;
         cfg_cont  <= 1'b0;
         cfg_limit <= '0;
         cfg_step  <= '0;
`ifdef SWEEP_PINGPONG_EN
         cfg_pp    <= 1'b0;
`endif
      end else begin
         // Event pulses self-clear regardless of clk_en.
         wrap <= 1'b0;
         done <= 1'b0;
         if (clk_en) begin
            unique case (state)
               IDLE: begin
                  if (start && !stop) begin
                     state     <= RUN;
                     busy      <= 1'b1;
                     cfg_dir   <= dir;
                     cfg_cont  <= continuous;
                     cfg_limit <= limit;
                     cfg_step  <= step_eff;
`ifdef SWEEP_PINGPONG_EN
                     cfg_pp    <= pingpong;
`endif
                     count     <= dir ? limit : '0;
                  end
               end
               RUN: begin
                  if (stop) begin
                     state <= PAUSE;
                  end else if (!term) begin
                     count <= nxt;
                  end else if (cfg_cont) begin
                     wrap  <= 1'b1;
                     count <= wrap_val;
`ifdef SWEEP_PINGPONG_EN
                     if (cfg_pp)
                        cfg_dir <= !cfg_dir;
`endif
                  end else begin
                     done  <= 1'b1;
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
               PAUSE: begin
                  if (stop) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     count <= '0;
                     done  <= 1'b1;
                  end else if (start) begin
                     state <= RUN;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
